hazard_fwd_ctrl: RTL and testbench

HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

---
 rtl/hazard_fwd_ctrl.sv | 156 +++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: operand forwarding selects, load-use stall and branch
// flush control for a five-stage pipeline. All outputs are registered.
// Optional feature: define HZ_PERF_CNT_EN to build the saturating
// stall-cycle counter; otherwise stall_count is tied to zero.
module hazard_fwd_ctrl #(
  parameter int RW     = 4,
  parameter int NSRC   = 3,
  parameter int LD_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [RW-1:0]        rd_ex,
  input  logic [RW-1:0]        rd_mem,
  input  logic [RW-1:0]        rd_wb,
  input  logic                 we_ex,
  input  logic                 we_mem,
  input  logic                 we_wb,
  input  logic                 ld_ex,
  input  logic [NSRC*RW-1:0]   src_id,
  input  logic [NSRC-1:0]      src_used,
  input  logic                 br_taken,
  output logic [2*NSRC-1:0]    fwd_sel,
  output logic                 cu_mux,
  output logic                 pc_ld,
  output logic                 if_id_ld,
  output logic                 flush_id,
  output logic [15:0]          stall_count
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // Bubble counter starts at LD_LAT-1 so LD_LAT=1 gives a single stall cycle.
  localparam logic [3:0] CNT_INIT = 4'(LD_LAT - 1);

  logic [1:0]          r_state;
  logic [3:0]          r_cnt;
  logic [2*NSRC-1:0]   r_fwd_sel;
  logic                r_cu_mux;
  logic                r_pc_ld;
  logic                r_if_id_ld;
  logic                r_flush_id;

  logic [2*NSRC-1:0]   w_fwd_next;
  logic [NSRC-1:0]     w_ex_hit;
  logic                w_hazard;
  logic [1:0]          w_state_next;
  logic [3:0]          w_cnt_next;

  // Per-operand forwarding select; a load in EX never forwards since its
  // data is not available until MEM.
  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      logic [RW-1:0] w_src;
      assign w_src = src_id[gi*RW +: RW];
      assign w_ex_hit[gi] = src_used[gi] & (rd_ex == w_src);
      assign w_fwd_next[2*gi +: 2] =
          (src_used[gi] & we_ex & ~ld_ex & (rd_ex == w_src)) ? 2'b01 :
          (src_used[gi] & we_mem & (rd_mem == w_src))        ? 2'b10 :
          (src_used[gi] & we_wb & (rd_wb == w_src))          ? 2'b11 :
                                                               2'b00;
    end
  endgenerate

  assign w_hazard = ld_ex & we_ex & (|w_ex_hit);

  // Next-state logic: a taken branch always wins over a stall.
  always_comb begin
    w_state_next = S_RUN;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_RUN: begin
        if (br_taken) begin
          w_state_next = S_FLUSH;
        end else if (w_hazard) begin
          w_state_next = S_STALL;
          w_cnt_next   = CNT_INIT;
        end
      end
      S_STALL: begin
        if (br_taken) begin
          w_state_next = S_FLUSH;
        end else if (r_cnt != 4'd0) begin
          w_state_next = S_STALL;
          w_cnt_next   = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_next = S_RUN;
      end
    endcase
  end

  // State, counter and registered outputs decoded from the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_RUN;
      r_cnt      <= 4'd0;
      r_fwd_sel  <= '0;
      r_cu_mux   <= 1'b1;
      r_pc_ld    <= 1'b1;
      r_if_id_ld <= 1'b1;
      r_flush_id <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_fwd_sel <= w_fwd_next;
      case (w_state_next)
        S_STALL: begin
          r_cu_mux   <= 1'b0;
          r_pc_ld    <= 1'b0;
          r_if_id_ld <= 1'b0;
          r_flush_id <= 1'b0;
        end
        S_FLUSH: begin
          r_cu_mux   <= 1'b0;
          r_pc_ld    <= 1'b1;
          r_if_id_ld <= 1'b1;
          r_flush_id <= 1'b1;
        end
        default: begin
          r_cu_mux   <= 1'b1;
          r_pc_ld    <= 1'b1;
          r_if_id_ld <= 1'b1;
          r_flush_id <= 1'b0;
        end
      endcase
    end
  end

  assign fwd_sel  = r_fwd_sel;
  assign cu_mux   = r_cu_mux;
  assign pc_ld    = r_pc_ld;
  assign if_id_ld = r_if_id_ld;
  assign flush_id = r_flush_id;

`ifdef HZ_PERF_CNT_EN
  logic [15:0] r_stall_count;

  // Count every edge that enters or stays in STALL, saturating at all-ones.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_count <= 16'd0;
    end else if ((w_state_next == S_STALL) && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed testbench for hazard_fwd_ctrl: one instance with LD_LAT=3 and
// one with the default LD_LAT=1, driven from the same inputs.
module tb_hazard_fwd_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  rd_ex, rd_mem, rd_wb;
  logic        we_ex, we_mem, we_wb, ld_ex, br_taken;
  logic [11:0] src_id;
  logic [2:0]  src_used;

  logic [5:0]  fwd_sel, fwd_sel1;
  logic        cu_mux, pc_ld, if_id_ld, flush_id;
  logic        cu_mux1, pc_ld1, if_id_ld1, flush_id1;
  logic [15:0] stall_count, stall_count1;

  int checks = 0;
  int errors = 0;

`ifdef HZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 CLK = ~CLK;

  hazard_fwd_ctrl #(.RW(4), .NSRC(3), .LD_LAT(3)) u_dut (
    .CLK(CLK), .RST(RST), .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .we_ex(we_ex), .we_mem(we_mem), .we_wb(we_wb), .ld_ex(ld_ex),
    .src_id(src_id), .src_used(src_used), .br_taken(br_taken),
    .fwd_sel(fwd_sel), .cu_mux(cu_mux), .pc_ld(pc_ld), .if_id_ld(if_id_ld),
    .flush_id(flush_id), .stall_count(stall_count)
  );

  hazard_fwd_ctrl u_dut1 (
    .CLK(CLK), .RST(RST), .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .we_ex(we_ex), .we_mem(we_mem), .we_wb(we_wb), .ld_ex(ld_ex),
    .src_id(src_id), .src_used(src_used), .br_taken(br_taken),
    .fwd_sel(fwd_sel1), .cu_mux(cu_mux1), .pc_ld(pc_ld1), .if_id_ld(if_id_ld1),
    .flush_id(flush_id1), .stall_count(stall_count1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control outputs of the LD_LAT=3 instance: {pc_ld, if_id_ld, cu_mux, flush_id}
  task automatic chk_ctl(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, pc_ld, if_id_ld, cu_mux, flush_id}, {28'd0, exp});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic benign();
    we_ex = 0; we_mem = 0; we_wb = 0; ld_ex = 0; br_taken = 0;
    src_used = 3'b000; src_id = 12'h000;
    rd_ex = 0; rd_mem = 0; rd_wb = 0;
  endtask

  // Load in EX writing r7, read by operand 1 -> load-use hazard.
  task automatic load_use();
    benign();
    ld_ex = 1; we_ex = 1; rd_ex = 4'd7;
    src_id = {4'd0, 4'd7, 4'd0}; src_used = 3'b010;
  endtask

  function automatic logic [31:0] exp_sc(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  initial begin
    // Reset with inputs that would otherwise forward from EX
    benign();
    RST = 1;
    we_ex = 1; rd_ex = 4'd5; src_id = {4'd0, 4'd0, 4'd5}; src_used = 3'b001; br_taken = 1;
    tick();
    chk("reset_fwd", {26'd0, fwd_sel}, 32'd0);
    chk_ctl("reset_ctl", 4'b1110);
    chk("reset_sc", {16'd0, stall_count}, 32'd0);
    $display("txn reset: fwd=%b ctl=%b%b%b%b", fwd_sel, pc_ld, if_id_ld, cu_mux, flush_id);

    // No matching source registers
    RST = 0; benign();
    rd_ex = 1; rd_mem = 2; rd_wb = 3; we_ex = 1; we_mem = 1; we_wb = 1;
    src_id = {4'd4, 4'd4, 4'd4}; src_used = 3'b111;
    tick();
    chk("nomatch_fwd", {26'd0, fwd_sel}, 32'd0);
    chk_ctl("nomatch_ctl", 4'b1110);
    $display("txn nomatch: fwd=%b", fwd_sel);

    // Priority EX > MEM > WB on operand 0
    rd_ex = 5; rd_mem = 5; rd_wb = 5; src_id = {4'd4, 4'd4, 4'd5};
    tick();
    chk("prio_ex", {26'd0, fwd_sel}, 32'b000001);
    $display("txn prio_ex: fwd=%b", fwd_sel);
    we_ex = 0;
    tick();
    chk("prio_mem", {26'd0, fwd_sel}, 32'b000010);
    $display("txn prio_mem: fwd=%b", fwd_sel);
    we_mem = 0;
    tick();
    chk("prio_wb", {26'd0, fwd_sel}, 32'b000011);
    $display("txn prio_wb: fwd=%b", fwd_sel);
    src_used = 3'b110;
    tick();
    chk("unused_op0", {26'd0, fwd_sel}, 32'd0);
    $display("txn unused_op0: fwd=%b", fwd_sel);

    // Each operand forwards from a different stage
    we_ex = 1; we_mem = 1; we_wb = 1; rd_ex = 1; rd_mem = 2; rd_wb = 3;
    src_id = {4'd3, 4'd2, 4'd1}; src_used = 3'b111;
    tick();
    chk("mixed_fwd", {26'd0, fwd_sel}, 32'b111001);
    $display("txn mixed: fwd=%b", fwd_sel);

    // Load in EX targets an unused operand: no stall, no forward
    benign();
    ld_ex = 1; we_ex = 1; rd_ex = 7; we_mem = 1; rd_mem = 7;
    src_id = {4'd7, 4'd1, 4'd2}; src_used = 3'b011;
    tick();
    chk("unused_load_fwd", {26'd0, fwd_sel}, 32'd0);
    chk_ctl("unused_load_ctl", 4'b1110);
    $display("txn unused_load: fwd=%b pc_ld=%b", fwd_sel, pc_ld);

    // Load-use: LD_LAT=3 stalls 3 cycles, LD_LAT=1 stalls 1; MEM forward, not EX
    load_use(); we_mem = 1; rd_mem = 7;
    tick();
    chk("lu_fwd_not_ex", {26'd0, fwd_sel}, 32'b001000);
    chk_ctl("lu_stall1", 4'b0000);
    chk("lu1_stall1", {31'd0, pc_ld1}, 32'd0);
    $display("txn stall1: pc_ld=%b pc_ld1=%b fwd=%b", pc_ld, pc_ld1, fwd_sel);
    benign();
    tick();
    chk_ctl("lu_stall2", 4'b0000);
    chk("lu1_run", {28'd0, pc_ld1, if_id_ld1, cu_mux1, flush_id1}, 32'b1110);
    $display("txn stall2: pc_ld=%b pc_ld1=%b", pc_ld, pc_ld1);
    tick();
    chk_ctl("lu_stall3", 4'b0000);
    $display("txn stall3: pc_ld=%b", pc_ld);
    tick();
    chk_ctl("lu_release", 4'b1110);
    chk("lu_sc", {16'd0, stall_count}, exp_sc(3));
    chk("lu1_sc", {16'd0, stall_count1}, exp_sc(1));
    $display("txn release: pc_ld=%b sc=%0d sc1=%0d", pc_ld, stall_count, stall_count1);

    // Load-use and taken branch together: flush, no stall
    load_use(); br_taken = 1;
    tick();
    chk_ctl("br_lu_flush", 4'b1101);
    $display("txn br_lu: flush_id=%b cu_mux=%b", flush_id, cu_mux);
    benign();
    tick();
    chk_ctl("br_lu_after", 4'b1110);
    chk("br_lu_sc", {16'd0, stall_count}, exp_sc(3));
    $display("txn br_lu_after: flush_id=%b sc=%0d", flush_id, stall_count);

    // FLUSH lasts one cycle even with br_taken held high
    br_taken = 1;
    tick();
    chk_ctl("flush_a", 4'b1101);
    tick();
    chk_ctl("flush_b_run", 4'b1110);
    $display("txn flush_hold: flush_id=%b", flush_id);
    br_taken = 0;

    // Taken branch aborts a stall
    load_use();
    tick();
    chk_ctl("abort_stall", 4'b0000);
    benign(); br_taken = 1;
    tick();
    chk_ctl("abort_flush", 4'b1101);
    chk("abort1_flush", {31'd0, flush_id1}, 32'd1);
    benign();
    tick();
    chk_ctl("abort_run", 4'b1110);
    chk("abort_sc", {16'd0, stall_count}, exp_sc(4));
    $display("txn abort: flush_id=%b sc=%0d", flush_id, stall_count);

    // Reset in the second stall cycle clears everything, no residual bubble
    load_use();
    tick();
    benign();
    tick();
    chk_ctl("rst_mid_stall2", 4'b0000);
    RST = 1; we_ex = 1; rd_ex = 4'd5; src_id = {4'd0, 4'd0, 4'd5}; src_used = 3'b001;
    tick();
    chk_ctl("rst_mid_ctl", 4'b1110);
    chk("rst_mid_fwd", {26'd0, fwd_sel}, 32'd0);
    chk("rst_mid_sc", {16'd0, stall_count}, 32'd0);
    RST = 0; benign();
    tick();
    chk_ctl("rst_mid_after", 4'b1110);
    $display("txn rst_mid: pc_ld=%b sc=%0d", pc_ld, stall_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
